// File: rtl/bridge_tx_uart_if.sv
// Handshake between the core chain's bus output and the UART response transmitter.
interface bridge_tx_uart_if;
  logic [15:0] data_i;
  logic        rw_i;
  logic        valid_i;
  logic        ready_o;

  modport master (output data_i, output rw_i, output valid_i, input ready_o);
  modport slave  (input data_i, input rw_i, input valid_i, output ready_o);
endinterface

// File: rtl/bridge_tx_uart.sv
// Manta bridge response path: serialises a read result as "D<hhhh>\r\n" over 8N1 UART.
module bridge_tx_uart #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic            clk,
  input  logic            rst,
  bridge_tx_uart_if.slave bus,
  output logic            tx
);

  localparam int                BAUD_W        = $clog2(CLOCKS_PER_BAUD);
  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [3:0]        LAST_DATA_BIT = 4'd8;
  localparam logic [2:0]        LAST_BYTE     = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [3:0]        bit_idx, bit_n;
  logic [2:0]        byte_idx, byte_n;
  logic [15:0]       data_q;
  logic              load;
  logic              tx_n;
  logic [7:0]        cur_byte;
  logic              baud_wrap;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] msg_byte(input logic [15:0] d, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h44;
      3'd1:    b = hex_ascii(d[15:12]);
      3'd2:    b = hex_ascii(d[11:8]);
      3'd3:    b = hex_ascii(d[7:4]);
      3'd4:    b = hex_ascii(d[3:0]);
      3'd5:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  assign baud_wrap  = (baud_cnt == BAUD_LAST);
  assign bus.ready_o = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      data_q   <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      tx       <= tx_n;
      if (load) begin
        data_q <= bus.data_i;
      end
    end
  end

  // Bit index runs 0 (start) .. 1-8 (data) .. 9 (stop); the last stop bit of byte 6 returns to IDLE.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid_i && !bus.rw_i) begin
          state_n = START;
          baud_n  = '0;
          bit_n   = '0;
          byte_n  = '0;
          load    = 1'b1;
        end
      end
      default: begin
        if (baud_wrap) begin
          baud_n = '0;
          bit_n  = bit_idx + 4'd1;
          case (state)
            START: state_n = DATA;
            DATA: begin
              if (bit_idx == LAST_DATA_BIT) begin
                state_n = STOP;
              end
            end
            default: begin
              bit_n = '0;
              if (byte_idx == LAST_BYTE) begin
                state_n = IDLE;
                byte_n  = '0;
              end else begin
                state_n = START;
                byte_n  = byte_idx + 3'd1;
              end
            end
          endcase
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
    endcase
  end

  // tx is registered from the next-state view so the line changes exactly on bit boundaries.
  always_comb begin
    cur_byte = msg_byte(data_q, byte_n);
    tx_n     = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte[3'(bit_n[2:0] - 3'd1)];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bridge_tx_uart.sv
// Self-checking bench for bridge_tx_uart: compares tx and ready_o each cycle against a string-based message model.
module tb_bridge_tx_uart;

  localparam int CPB     = 4;
  localparam int MSG_CYC = 70 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  int   tests_run = 0;
  int   tests_failed = 0;

  bridge_tx_uart_if bus ();

  bridge_tx_uart #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b at time %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic rw);
    @(negedge clk);
    bus.data_i  = d;
    bus.rw_i    = rw;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
  endtask

  task automatic idleCheck(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput("idle_tx", tx, 1'b1);
      checkOutput("idle_ready", bus.ready_o, 1'b1);
    end
  endtask

  // Called just after the accepting edge; optionally injects a stray valid, aborts early, or chains a follow-up.
  task automatic expectMessage(input logic [15:0] d, input int stop_k, input int pulse_k,
                               input logic [15:0] pulse_d, input bit chain, input logic [15:0] next_d);
    string      s;
    logic [7:0] msg [7];
    logic [9:0] frame;
    s = $sformatf("d%h", d);
    s = s.toupper();
    for (int i = 0; i < 5; i++) msg[i] = s[i];
    msg[5] = 8'h0D;
    msg[6] = 8'h0A;
    for (int k = 0; k < stop_k; k++) begin
      @(negedge clk);
      frame = {1'b1, msg[k / (10 * CPB)], 1'b0};
      checkOutput("msg_tx", tx, frame[(k / CPB) % 10]);
      checkOutput("msg_ready", bus.ready_o, 1'b0);
      if (k == pulse_k + 1) bus.valid_i = 1'b0;
      if (k == pulse_k) begin
        bus.data_i  = pulse_d;
        bus.rw_i    = 1'b0;
        bus.valid_i = 1'b1;
      end
      if (chain && k == MSG_CYC - 1) begin
        bus.data_i  = next_d;
        bus.rw_i    = 1'b0;
        bus.valid_i = 1'b1;
      end
    end
    if (stop_k == MSG_CYC) begin
      @(negedge clk);
      checkOutput("end_tx", tx, 1'b1);
      checkOutput("end_ready", bus.ready_o, 1'b1);
      if (chain) begin
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
      end
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] pd;
    bus.data_i  = '0;
    bus.rw_i    = 1'b0;
    bus.valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    idleCheck(20);

    applyStimulus(16'hBEEF, 1'b0);
    expectMessage(16'hBEEF, MSG_CYC, -10, 16'h0000, 1'b0, 16'h0000);

    applyStimulus(16'h0000, 1'b0);
    expectMessage(16'h0000, MSG_CYC, -10, 16'h0000, 1'b1, 16'h9A0F);
    expectMessage(16'h9A0F, MSG_CYC, -10, 16'h0000, 1'b0, 16'h0000);

    applyStimulus(16'h1234, 1'b1);
    idleCheck(10);

    applyStimulus(16'h7C01, 1'b0);
    expectMessage(16'h7C01, MSG_CYC, 100, 16'h5555, 1'b0, 16'h0000);
    idleCheck(40);

    applyStimulus(16'h3C7A, 1'b0);
    expectMessage(16'h3C7A, 2 * 10 * CPB + 10, -10, 16'h0000, 1'b0, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_ready", bus.ready_o, 1'b1);
    rst = 1'b0;
    idleCheck(3);
    applyStimulus(16'h00FF, 1'b0);
    expectMessage(16'h00FF, MSG_CYC, -10, 16'h0000, 1'b0, 16'h0000);

    for (int n = 0; n < 10; n++) begin
      d  = 16'($urandom);
      pd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(d, 1'b1);
        idleCheck(5);
      end else begin
        applyStimulus(d, 1'b0);
        expectMessage(d, MSG_CYC, int'($urandom_range(0, MSG_CYC - 3)), pd, 1'b0, 16'h0000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
